// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: reset/bubble defaults, fetch FSM encoding and the
// IF/ID payload record.
package rv32i_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_RUN  = 2'd0,
    FETCH_HOLD = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
  } if_id_t;

endpackage

// File: rtl/rv32i_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and the instruction memory (slave).
interface rv32i_fetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register; flush loads a bubble and wins over a disabled
// (stalled) register.
module if_id_reg
  import rv32i_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        flush,
  input  if_id_t      data,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D
);

  localparam if_id_t BUBBLE = '{instr: NOP_INSTR, pc: 32'd0, pcPlus4: 32'd0};

  if_id_t ifId_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifId_q <= BUBBLE;
    end else if (flush) begin
      ifId_q <= BUBBLE;
    end else if (enable) begin
      ifId_q <= data;
    end
  end

  assign InstrD   = ifId_q.instr;
  assign PCD      = ifId_q.pc;
  assign PCPlus4D = ifId_q.pcPlus4;

endmodule

// File: rtl/rv32i_fetch.sv
// RV32I fetch stage: PC register, single-outstanding instruction-memory
// request FSM (RUN/HOLD/DROP), one-entry hold buffer and the IF/ID register.
module rv32i_fetch
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  rv32i_fetch_if.master imem,
  input  logic          StallD,
  input  logic          FlushD,
  input  logic          PCSrcE,
  input  logic [31:0]   PCTargetE,
  output logic [31:0]   InstrD,
  output logic [31:0]   PCD,
  output logic [31:0]   PCPlus4D,
  output logic          FetchBusyF
);

  localparam if_id_t BUBBLE = '{instr: NOP_INSTR, pc: 32'd0, pcPlus4: 32'd0};

  fetch_state_e state_q, state_d;
  logic [31:0]  pcF_q, pcF_d;
  logic [31:0]  target_q, target_d;
  if_id_t       hold_q, hold_d;

  logic [31:0]  pcPlus4F;
  if_id_t       fetched;
  if_id_t       deliver;
  logic         deliverValid;
  if_id_t       ifIdData;

  assign pcPlus4F = pcF_q + 32'd4;
  assign fetched  = '{instr: imem.imem_rdata, pc: pcF_q, pcPlus4: pcPlus4F};

  // The request stays up (address = PCF) in RUN and DROP; HOLD parks the bus.
  assign imem.imem_req  = (state_q != FETCH_HOLD);
  assign imem.imem_addr = pcF_q;
  assign FetchBusyF     = (imem.imem_req && !imem.imem_rvalid) || (state_q == FETCH_DROP);

  always_comb begin
    state_d      = state_q;
    pcF_d        = pcF_q;
    target_d     = target_q;
    hold_d       = hold_q;
    deliverValid = 1'b0;
    deliver      = fetched;
    unique case (state_q)
      FETCH_RUN: begin
        if (imem.imem_rvalid) begin
          if (PCSrcE) begin
            pcF_d = PCTargetE;
          end else begin
            pcF_d = pcPlus4F;
            if (StallD) begin
              hold_d  = fetched;
              state_d = FETCH_HOLD;
            end else begin
              deliverValid = 1'b1;
            end
          end
        end else if (PCSrcE) begin
          target_d = PCTargetE;
          state_d  = FETCH_DROP;
        end
      end
      FETCH_HOLD: begin
        if (PCSrcE) begin
          pcF_d   = PCTargetE;
          state_d = FETCH_RUN;
        end else if (!StallD) begin
          deliver      = hold_q;
          deliverValid = 1'b1;
          state_d      = FETCH_RUN;
        end
      end
      FETCH_DROP: begin
        // A redirect arriving alongside the stale response is the newest target.
        if (PCSrcE) begin
          target_d = PCTargetE;
        end
        if (imem.imem_rvalid) begin
          pcF_d   = PCSrcE ? PCTargetE : target_q;
          state_d = FETCH_RUN;
        end
      end
      default: begin
        state_d = FETCH_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FETCH_RUN;
      pcF_q    <= RESET_PC;
      target_q <= 32'd0;
      hold_q   <= BUBBLE;
    end else begin
      state_q  <= state_d;
      pcF_q    <= pcF_d;
      target_q <= target_d;
      hold_q   <= hold_d;
    end
  end

  assign ifIdData = deliverValid ? deliver : BUBBLE;

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (!StallD),
    .flush    (FlushD),
    .data     (ifIdData),
    .InstrD   (InstrD),
    .PCD      (PCD),
    .PCPlus4D (PCPlus4D)
  );

endmodule

// File: tb/tb_rv32i_fetch.sv
// Self-checking bench for rv32i_fetch: directed scenarios with literal
// expectations, then randomized hazards and memory latency against a model.
module tb_rv32i_fetch;
  import rv32i_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam if_id_t BUBBLE = '{instr: NOP, pc: 32'd0, pcPlus4: 32'd0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        StallD = 1'b0;
  logic        FlushD = 1'b0;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = 32'd0;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        FetchBusyF;

  int checks = 0;
  int errors = 0;

  // memory-side bookkeeping
  int latMode = 0;
  int curLat = 0;
  int waitCnt = 0;
  bit inFlight = 1'b0;

  // reference model state
  logic [31:0] mPc;
  logic [31:0] mTarget;
  bit          mDrop;
  if_id_t      heldQ[$];
  if_id_t      mIfId;

  rv32i_fetch_if imem ();

  rv32i_fetch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem       (imem),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
    .FetchBusyF (FetchBusyF)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0093;
    return (a << 5) | 32'h0000_0033;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // One cycle of stimulus plus the memory's response, applied at the falling edge.
  task automatic applyStimulus(input logic stall, input logic flush, input logic pcsrc,
                               input logic [31:0] target);
    @(negedge clk);
    rst_n     = 1'b1;
    StallD    = stall;
    FlushD    = flush;
    PCSrcE    = pcsrc;
    PCTargetE = target;
    if (imem.imem_req) begin
      if (!inFlight) begin
        inFlight = 1'b1;
        waitCnt  = 0;
        curLat   = (latMode < 0) ? int'($urandom_range(0, 3)) : latMode;
      end
      if (waitCnt >= curLat) begin
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = memWord(imem.imem_addr);
        inFlight         = 1'b0;
      end else begin
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = 32'hDEAD_BEEF;
        waitCnt++;
      end
    end else begin
      imem.imem_rvalid = 1'b0;
      imem.imem_rdata  = 32'hDEAD_BEEF;
      inFlight         = 1'b0;
    end
  endtask

  task automatic applyRandom();
    logic [31:0] t;
    t = 32'($urandom_range(0, 255)) << 2;
    if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFF8;
    applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) == 0, t);
  endtask

  task automatic modelReset();
    mPc     = 32'h0;
    mTarget = 32'h0;
    mDrop   = 1'b0;
    heldQ.delete();
    mIfId   = BUBBLE;
  endtask

  // Advance the model across one rising edge using the inputs of this cycle.
  task automatic modelStep();
    if_id_t arrived;
    if_id_t handed;
    bit     handOver;
    bit     respond;
    handOver = 1'b0;
    handed   = BUBBLE;
    respond  = imem.imem_rvalid && (heldQ.size() == 0);
    arrived  = '{instr: imem.imem_rdata, pc: mPc, pcPlus4: mPc + 32'd4};
    if (heldQ.size() != 0) begin
      if (PCSrcE) begin
        heldQ.delete();
        mPc = PCTargetE;
      end else if (!StallD) begin
        handed   = heldQ.pop_front();
        handOver = 1'b1;
      end
    end else if (PCSrcE) begin
      mTarget = PCTargetE;
      if (respond) begin
        mPc   = PCTargetE;
        mDrop = 1'b0;
      end else begin
        mDrop = 1'b1;
      end
    end else if (respond) begin
      if (mDrop) begin
        mPc   = mTarget;
        mDrop = 1'b0;
      end else begin
        mPc = mPc + 32'd4;
        if (StallD) begin
          heldQ.push_back(arrived);
        end else begin
          handed   = arrived;
          handOver = 1'b1;
        end
      end
    end
    if (FlushD) mIfId = BUBBLE;
    else if (!StallD) mIfId = handOver ? handed : BUBBLE;
  endtask

  initial begin : compareProc
    logic expReq;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        modelReset();
        checkOutput("rst_InstrD", InstrD, mIfId.instr);
        checkOutput("rst_PCD", PCD, mIfId.pc);
        checkOutput("rst_imem_addr", imem.imem_addr, mPc);
        continue;
      end
      expReq = (heldQ.size() == 0);
      checkOutput("imem_req", 32'(imem.imem_req), 32'(expReq));
      if (expReq) checkOutput("imem_addr", imem.imem_addr, mPc);
      checkOutput("FetchBusyF", 32'(FetchBusyF), 32'((expReq && !imem.imem_rvalid) || mDrop));
      checkOutput("InstrD", InstrD, mIfId.instr);
      checkOutput("PCD", PCD, mIfId.pc);
      checkOutput("PCPlus4D", PCPlus4D, mIfId.pcPlus4);
      modelStep();
    end
  end

  initial begin : driver
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata  = 32'h0;
    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset_InstrD", InstrD, NOP);
    checkOutput("reset_PCD", PCD, 32'h0);
    checkOutput("reset_PCPlus4D", PCPlus4D, 32'h0);
    checkOutput("reset_imem_addr", imem.imem_addr, 32'h0);
    repeat (2) @(posedge clk);

    // zero-wait memory: first word lands after one edge
    latMode = 0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    checkOutput("first_InstrD", InstrD, 32'h0000_0093);
    checkOutput("first_PCD", PCD, 32'h0);
    checkOutput("first_PCPlus4D", PCPlus4D, 32'h4);
    checkOutput("first_PCF", imem.imem_addr, 32'h4);

    // one wait cycle: busy while waiting, one bubble per fetch
    latMode = 1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    #3 checkOutput("wait_busy", 32'(FetchBusyF), 32'd1);
    @(posedge clk); #1;
    checkOutput("wait_bubble", InstrD, NOP);
    checkOutput("wait_bubble_PCD", PCD, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    checkOutput("wait_word", InstrD, memWord(32'h4));
    checkOutput("wait_addr", imem.imem_addr, 32'h8);

    // stall for three cycles with a word in hand
    latMode = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      @(posedge clk); #1;
      checkOutput("hold_req", 32'(imem.imem_req), 32'd0);
      checkOutput("hold_InstrD", InstrD, memWord(32'h4));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    checkOutput("hold_release_InstrD", InstrD, memWord(32'h8));
    checkOutput("hold_release_PCD", PCD, 32'h8);
    checkOutput("hold_release_addr", imem.imem_addr, 32'hC);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    checkOutput("after_hold_PCD", PCD, 32'hC);

    // redirect while a 3-cycle response is pending
    latMode = 2;
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h100);
    @(posedge clk); #1;
    checkOutput("drop_busy", 32'(FetchBusyF), 32'd1);
    checkOutput("drop_addr_held", imem.imem_addr, 32'h10);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    checkOutput("drop_new_addr", imem.imem_addr, 32'h100);
    checkOutput("drop_discard", InstrD, NOP);

    // flush beats stall; PC wrap at the top of memory
    latMode = 0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    @(posedge clk); #1;
    checkOutput("flush_InstrD", InstrD, NOP);
    checkOutput("flush_PCD", PCD, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    checkOutput("wrap_fetch_addr", imem.imem_addr, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    checkOutput("wrap_PCD", PCD, 32'hFFFF_FFFC);
    checkOutput("wrap_PCPlus4D", PCPlus4D, 32'h0);
    checkOutput("wrap_next_PCF", imem.imem_addr, 32'h0);

    latMode = -1;
    repeat (2000) applyRandom();

    // asynchronous reset in the middle of a cycle
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_InstrD", InstrD, NOP);
    checkOutput("async_rst_PCPlus4D", PCPlus4D, 32'h0);
    checkOutput("async_rst_addr", imem.imem_addr, 32'h0);
    inFlight = 1'b0;
    repeat (2) @(posedge clk);
    repeat (300) applyRandom();

    @(negedge clk);
    #4;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
